// File: rtl/ata_pio_burst_if.sv
`default_nettype none
// ============================================================================
//  Module   : ata_pio_burst_if
//  Purpose  : Control, ATA-bridge strobe and host FIFO signals of the
//             ata_pio_burst sector engine, bundled with engine/host modports.
//  Revision : 1.0
// ============================================================================
interface ata_pio_burst_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   // burst control
   logic             start;
   logic             dir;
   logic [7:0]       nsectors;
   logic             abort;
   logic             busy;
   logic             done;
   logic             err;
   // bridge side
   logic             cs5;
   logic             moe;
   logic             mwe;
   logic             a3;
   logic             a2;
   logic             a1;
   logic             a0;
   logic             exprdy;
   logic [15:0]      d_in;
   logic [15:0]      d_out;
   logic             d_oe;
   // host FIFO side
   logic             h_wr;
   logic [15:0]      h_wdata;
   logic             h_rd;
   logic [15:0]      h_rdata;
   logic             h_full;
   logic             h_empty;
   logic [LVL_W-1:0] h_level;

   // engine view
   modport slave (
      input  start, dir, nsectors, abort, exprdy, d_in, h_wr, h_wdata, h_rd,
      output busy, done, err, cs5, moe, mwe, a3, a2, a1, a0, d_out, d_oe,
             h_rdata, h_full, h_empty, h_level
   );

   // host / bridge environment view
   modport master (
      output start, dir, nsectors, abort, exprdy, d_in, h_wr, h_wdata, h_rd,
      input  busy, done, err, cs5, moe, mwe, a3, a2, a1, a0, d_out, d_oe,
             h_rdata, h_full, h_empty, h_level
   );
endinterface
`default_nettype wire

// File: rtl/ata_pio_burst.sv
`default_nettype none
// ============================================================================
//  Module   : ata_pio_burst
//  Purpose  : Sector-burst engine that drives the ATA chip-select bridge
//             strobes for data-register transfers and moves 16-bit words
//             between the IDE data register and a host-side FIFO.
//  Revision : 1.0
// ============================================================================
module ata_pio_burst #(
   parameter int FIFO_DEPTH       = 16,
   parameter int WORDS_PER_SECTOR = 256,
   parameter int GAP              = 4,
   parameter int TIMEOUT          = 255
) (
   input  logic           clk,
   input  logic           reset,
   ata_pio_burst_if.slave bus
);
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W  = $clog2(GAP + 1);

   localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0]  c_gap_last  = GAP_W'(GAP - 1);
   localparam logic [16:0]       c_wps       = 17'(WORDS_PER_SECTOR);
   localparam logic [AW:0]       c_depth     = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_STROBE  = 3'd2,
      S_WAIT_LO = 3'd3,
      S_WAIT_HI = 3'd4,
      S_GAP     = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic                dir_q, dir_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                cs5_q, cs5_d;
   logic                moe_q, moe_d;
   logic                mwe_q, mwe_d;
   logic                d_oe_q, d_oe_d;
   logic [15:0]         d_out_q, d_out_d;
   logic [16:0]         remaining_q, remaining_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic                abort_q, abort_d;
   logic                tmo_q, tmo_d;
   logic [AW:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]         rd_ptr_q, rd_ptr_d;
   logic [15:0]         mem_q [FIFO_DEPTH];

   logic [AW:0]         level;
   logic                fifo_full, fifo_empty;
   logic [15:0]         fifo_head;
   logic [15:0]         push_data;
   logic                eng_push, eng_pop, flush, tmo_hit;
   logic                push_ok, pop_ok;
   logic [16:0]         nsec_words;

   assign level      = wr_ptr_q - rd_ptr_q;
   assign fifo_full  = (level == c_depth);
   assign fifo_empty = (level == '0);
   assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];
   // Read bursts fill the FIFO from the IDE bus, write bursts from the host.
   assign push_data  = dir_q ? bus.d_in : bus.h_wdata;
   // A sector count of zero stands for 256 sectors.
   assign nsec_words = ((bus.nsectors == 8'd0) ? 17'd256 : {9'd0, bus.nsectors}) * c_wps;

   // Burst sequencer: next-state and next-output computation.
   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      cs5_d       = cs5_q;
      moe_d       = moe_q;
      mwe_d       = mwe_q;
      d_oe_d      = d_oe_q;
      d_out_d     = d_out_q;
      remaining_d = remaining_q;
      wait_cnt_d  = wait_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      abort_d     = abort_q;
      tmo_d       = tmo_q;
      eng_push    = 1'b0;
      eng_pop     = 1'b0;
      flush       = 1'b0;
      tmo_hit     = 1'b0;

      // Abort requests are remembered for the whole burst and acted on at GAP exit.
      if (state_q != S_IDLE && bus.abort) begin
         abort_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d     = S_SETUP;
               busy_d      = 1'b1;
               err_d       = 1'b0;
               dir_d       = bus.dir;
               remaining_d = nsec_words;
               abort_d     = 1'b0;
               tmo_d       = 1'b0;
               flush       = 1'b1;
            end
         end
         S_SETUP: begin
            // Hold off while there is no room (read) or no data (write).
            if (!(dir_q ? fifo_full : fifo_empty)) begin
               cs5_d = 1'b0;
               if (!dir_q) begin
                  d_out_d = fifo_head;
                  eng_pop = 1'b1;
                  d_oe_d  = 1'b1;
               end
               state_d = S_STROBE;
            end
         end
         S_STROBE: begin
            if (dir_q) moe_d = 1'b0;
            else       mwe_d = 1'b0;
            wait_cnt_d = '0;
            state_d    = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (!bus.exprdy) begin
               wait_cnt_d = '0;
               state_d    = S_WAIT_HI;
            end else if (wait_cnt_q == c_wait_last) begin
               tmo_hit = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_WAIT_HI: begin
            if (bus.exprdy) begin
               eng_push    = dir_q;
               cs5_d       = 1'b1;
               moe_d       = 1'b1;
               mwe_d       = 1'b1;
               remaining_d = remaining_q - 17'd1;
               gap_cnt_d   = '0;
               state_d     = S_GAP;
            end else if (wait_cnt_q == c_wait_last) begin
               tmo_hit = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            // Write data is held for exactly one cycle past the strobe release.
            d_oe_d = 1'b0;
            if (gap_cnt_q == c_gap_last) begin
               if (remaining_q == '0 || abort_q || tmo_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_SETUP;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A stuck bridge: release everything and finish the burst via GAP.
      if (tmo_hit) begin
         err_d     = 1'b1;
         tmo_d     = 1'b1;
         cs5_d     = 1'b1;
         moe_d     = 1'b1;
         mwe_d     = 1'b1;
         d_oe_d    = 1'b0;
         gap_cnt_d = '0;
         state_d   = S_GAP;
      end
   end

   // FIFO pointer update; full-push and empty-pop requests are dropped.
   always_comb begin
      push_ok  = (eng_push | (bus.h_wr & ~dir_q)) & ~fifo_full;
      pop_ok   = (eng_pop  | (bus.h_rd &  dir_q)) & ~fifo_empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         dir_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cs5_q       <= 1'b1;
         moe_q       <= 1'b1;
         mwe_q       <= 1'b1;
         d_oe_q      <= 1'b0;
         d_out_q     <= '0;
         remaining_q <= '0;
         wait_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         abort_q     <= 1'b0;
         tmo_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cs5_q       <= cs5_d;
         moe_q       <= moe_d;
         mwe_q       <= mwe_d;
         d_oe_q      <= d_oe_d;
         d_out_q     <= d_out_d;
         remaining_q <= remaining_d;
         wait_cnt_q  <= wait_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         abort_q     <= abort_d;
         tmo_q       <= tmo_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.err     = err_q;
   assign bus.cs5     = cs5_q;
   assign bus.moe     = moe_q;
   assign bus.mwe     = mwe_q;
   assign bus.a3      = 1'b0;
   assign bus.a2      = 1'b0;
   assign bus.a1      = 1'b0;
   assign bus.a0      = 1'b0;
   assign bus.d_out   = d_out_q;
   assign bus.d_oe    = d_oe_q;
   assign bus.h_rdata = fifo_head;
   assign bus.h_full  = fifo_full;
   assign bus.h_empty = fifo_empty;
   assign bus.h_level = level;
endmodule
`default_nettype wire

// File: tb/tb_ata_pio_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ata_pio_burst
//  Purpose  : Self-checking bench for ata_pio_burst: randomized bridge and
//             host behaviour against a word-sequence reference model.
//  Revision : 1.0
// ============================================================================
module tb_ata_pio_burst;
   localparam int GAP     = 4;
   localparam int TIMEOUT = 255;
   localparam int WPS     = 256;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ata_pio_burst_if #(.FIFO_DEPTH(16)) bus ();

   ata_pio_burst #(
      .FIFO_DEPTH       (16),
      .WORDS_PER_SECTOR (WPS),
      .GAP              (GAP),
      .TIMEOUT          (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // main-owned controls for the bridge model
   logic        bridge_en;
   int          win_lo, win_hi, abort_at;
   int          rd_base, wr_base, pushed;
   logic        abort_main;
   logic [15:0] wq [512];
   // bridge-owned
   logic        abort_br;
   int          rd_cnt, wr_cnt, early_bad;
   logic [15:0] wcap [512];
   // monitor-owned
   int          done_cnt, hyg_bad, oe_bad, min_gap;

   assign bus.abort = abort_main | abort_br;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Bridge model: answers each strobe with an exprdy-low window of random length.
   initial begin
      bus.exprdy = 1'b1;
      bus.d_in   = '0;
      abort_br   = 1'b0;
      rd_cnt     = 0;
      wr_cnt     = 0;
      early_bad  = 0;
      forever begin
         @(posedge clk); #1;
         if (bridge_en && !bus.cs5 && (!bus.moe || !bus.mwe)) begin
            int   win;
            int   idx;
            logic is_rd;
            win   = $urandom_range(win_hi, win_lo);
            is_rd = !bus.moe;
            if (is_rd) begin
               idx      = rd_cnt - rd_base;
               bus.d_in = 16'(idx);
            end else begin
               idx = wr_cnt - wr_base;
               if (idx >= pushed) early_bad++;
               if (idx < 512) wcap[idx] = bus.d_out;
            end
            bus.exprdy = 1'b0;
            for (int k = 0; k < win; k++) begin
               abort_br = (is_rd && idx == abort_at && k == 1);
               @(posedge clk); #1;
            end
            abort_br   = 1'b0;
            bus.exprdy = 1'b1;
            if (is_rd) rd_cnt++;
            else       wr_cnt++;
            for (int k = 0; k < 8 && !bus.cs5; k++) begin
               @(posedge clk); #1;
            end
         end
      end
   end

   // Bus monitor: strobe hygiene, cs5 spacing, write-enable window, done pulses.
   initial begin
      int   hi_run;
      logic gap_valid, prev_cs5, prev_mwe, oe_next;
      done_cnt = 0; hyg_bad = 0; oe_bad = 0; min_gap = 1000;
      hi_run = 0; gap_valid = 1'b0; prev_cs5 = 1'b1; prev_mwe = 1'b1; oe_next = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.start) min_gap = 1000;
         if (bus.done) done_cnt++;
         if (!bus.moe && !bus.mwe) hyg_bad++;
         if (bus.cs5 && (!bus.moe || !bus.mwe)) hyg_bad++;
         if (!bus.mwe && !bus.d_oe) oe_bad++;
         if (!bus.moe && bus.d_oe) oe_bad++;
         if (oe_next && bus.d_oe) oe_bad++;
         oe_next = 1'b0;
         if (bus.cs5 && !prev_cs5 && !prev_mwe) begin
            if (!bus.d_oe) oe_bad++;
            oe_next = 1'b1;
         end
         if (bus.cs5) hi_run++;
         else begin
            if (prev_cs5 && gap_valid && hi_run < min_gap) min_gap = hi_run;
            hi_run = 0;
         end
         gap_valid = bus.busy && (gap_valid || !bus.cs5);
         prev_cs5  = bus.cs5;
         prev_mwe  = bus.mwe;
      end
   end

   task automatic start_burst(input logic d, input logic [7:0] ns);
      bus.dir      = d;
      bus.nsectors = ns;
      bus.start    = 1'b1;
      rd_base      = rd_cnt;
      wr_base      = wr_cnt;
      pushed       = 0;
      @(posedge clk); #1;
      bus.start    = 1'b0;
   endtask

   task automatic pulse_abort();
      abort_main = 1'b1;
      @(posedge clk); #1;
      abort_main = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int d0, input int budget);
      int cyc = 0;
      while (done_cnt == d0 && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk(tag, (cyc < budget), 1'b1);
   endtask

   // Host pops with given probability; every popped word must be the next in sequence.
   task automatic host_read(input int pct, input int first, input int d0, input int budget,
                            output int npop);
      int cyc = 0;
      npop = 0;
      while (!(done_cnt != d0 && !bus.busy && bus.h_empty) && cyc < budget) begin
         if (!bus.h_empty && $urandom_range(99, 0) < pct) begin
            chk("rdata", bus.h_rdata, 16'(first + npop));
            npop++;
            bus.h_rd = 1'b1;
         end else begin
            bus.h_rd = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.h_rd = 1'b0;
      chk("rd_in_budget", (cyc < budget), 1'b1);
   endtask

   // Host fills the FIFO at once, then pushes randomly as space appears.
   task automatic host_write(input int total, input int pct, input int d0, input int budget);
      int          cyc = 0;
      logic [15:0] w;
      while (!(done_cnt != d0 && !bus.busy) && cyc < budget) begin
         if (pushed < total && !bus.h_full && (pushed < 16 || $urandom_range(99, 0) < pct)) begin
            w           = 16'($urandom);
            wq[pushed]  = w;
            bus.h_wdata = w;
            bus.h_wr    = 1'b1;
            pushed++;
         end else begin
            bus.h_wr = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.h_wr = 1'b0;
      chk("wr_in_budget", (cyc < budget), 1'b1);
   endtask

   initial begin
      int d0, npop, acc, cs_low, n;
      reset = 1'b1; bus.start = 1'b0; bus.dir = 1'b0; bus.nsectors = '0;
      bus.h_wr = 1'b0; bus.h_wdata = '0; bus.h_rd = 1'b0; abort_main = 1'b0;
      bridge_en = 1'b1; win_lo = 1; win_hi = 3; abort_at = -1;
      rd_base = 0; wr_base = 0; pushed = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs5", bus.cs5, 1);      chk("rst_moe", bus.moe, 1);
      chk("rst_mwe", bus.mwe, 1);      chk("rst_d_oe", bus.d_oe, 0);
      chk("rst_d_out", bus.d_out, 0);  chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);    chk("rst_err", bus.err, 0);
      chk("rst_level", bus.h_level, 0); chk("rst_empty", bus.h_empty, 1);
      chk("rst_full", bus.h_full, 0);
      chk("rst_addr", {bus.a3, bus.a2, bus.a1, bus.a0}, 0);
      chk("rst_remaining", dut.remaining_q, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // abort while idle must be ignored; then a full one-sector read, 16-cycle window
      pulse_abort();
      chk("idle_abort_busy", bus.busy, 0);
      win_lo = 16; win_hi = 16;
      d0 = done_cnt;
      start_burst(1'b1, 8'd1);
      chk("start_busy", bus.busy, 1);
      host_read(100, 0, d0, 20000, npop);
      chk("rd1_words", npop, WPS);
      chk("rd1_access", rd_cnt - rd_base, WPS);
      chk("rd1_done", done_cnt - d0, 1);
      chk("rd1_gap", (min_gap >= GAP), 1);
      chk("rd1_err", bus.err, 0);

      // one-sector write with random host pacing
      win_lo = 1; win_hi = 4;
      d0 = done_cnt;
      start_burst(1'b0, 8'd1);
      host_write(WPS, 30, d0, 20000);
      chk("wr_access", wr_cnt - wr_base, WPS);
      for (int i = 0; i < WPS; i++) chk("wdata", wcap[i], wq[i]);
      chk("wr_no_early", early_bad, 0);
      chk("wr_oe", oe_bad, 0);
      chk("wr_done", done_cnt - d0, 1);

      // read backpressure: no pops until the FIFO fills
      win_lo = 1; win_hi = 3;
      d0 = done_cnt;
      start_burst(1'b1, 8'd1);
      n = 0;
      while (bus.h_level != 5'd16 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_filled", bus.h_level, 16);
      acc = rd_cnt; cs_low = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (!bus.cs5) cs_low++;
      end
      chk("bp_stall_cs5", cs_low, 0);
      chk("bp_stall_acc", rd_cnt - acc, 0);
      chk("bp_busy", bus.busy, 1);
      chk("bp_pop0", bus.h_rdata, 16'd0);
      bus.h_rd = 1'b1;
      @(posedge clk); #1;
      bus.h_rd = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("bp_one_more", rd_cnt - acc, 1);
      chk("bp_refull", bus.h_level, 16);
      host_read(70, 1, d0, 20000, npop);
      chk("bp_words", npop + 1, WPS);
      chk("bp_done", done_cnt - d0, 1);

      // timeout: bridge never answers
      bridge_en = 1'b0;
      d0 = done_cnt;
      start_burst(1'b1, 8'd1);
      n = 0;
      while (bus.moe && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("tmo_moe_low", bus.moe, 0);
      n = 0;
      while (!bus.err && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("tmo_cycles", n, TIMEOUT);
      chk("tmo_cs5", bus.cs5, 1);
      chk("tmo_moe", bus.moe, 1);
      chk("tmo_mwe", bus.mwe, 1);
      chk("tmo_oe", bus.d_oe, 0);
      wait_done("tmo_done_seen", d0, 50);
      @(posedge clk); #1;
      chk("tmo_done_once", done_cnt - d0, 1);
      chk("tmo_idle", bus.busy, 0);
      chk("tmo_sticky", bus.err, 1);

      // next start clears err; nsectors=0 loads 65536, then abort after one word
      bridge_en = 1'b1;
      d0 = done_cnt;
      start_burst(1'b1, 8'd0);
      chk("err_cleared", bus.err, 0);
      chk("rem_65536", dut.remaining_q, 17'd65536);
      pulse_abort();
      wait_done("ab0_done_seen", d0, 200);
      chk("ab0_access", rd_cnt - rd_base, 1);

      // abort during WAIT_HI of word 10: words 0..10 transferred, nothing more
      win_lo = 3; win_hi = 5; abort_at = 10;
      d0 = done_cnt;
      start_burst(1'b1, 8'd1);
      host_read(100, 0, d0, 5000, npop);
      abort_at = -1;
      chk("ab_words", npop, 11);
      chk("ab_access", rd_cnt - rd_base, 11);
      chk("ab_done", done_cnt - d0, 1);

      // reset during WAIT_LO of a write with data queued
      bridge_en = 1'b0;
      start_burst(1'b0, 8'd1);
      for (int i = 0; i < 8; i++) begin
         bus.h_wdata = 16'($urandom);
         bus.h_wr    = 1'b1;
         @(posedge clk); #1;
      end
      bus.h_wr = 1'b0;
      n = 0;
      while (bus.mwe && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rw_mwe_low", bus.mwe, 0);
      chk("rw_level", bus.h_level, 7);
      d0 = done_cnt;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rw_cs5", bus.cs5, 1);
      chk("rw_moe", bus.moe, 1);
      chk("rw_mwe", bus.mwe, 1);
      chk("rw_oe", bus.d_oe, 0);
      chk("rw_level0", bus.h_level, 0);
      chk("rw_busy", bus.busy, 0);
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("rw_no_done", done_cnt - d0, 0);

      chk("hygiene", hyg_bad, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ata_pio_burst.md
Name: ata_pio_burst

Overview:
- Sector-burst engine directly upstream of the ATA chip-select bridge. It drives the bridge's CPU-side strobes (cs5, moe, mwe, a3..a0) in place of the EP72xx for data-register transfers.
- It moves whole sectors of 16-bit words between the IDE data register and a 16-word host-side FIFO.
- The host programs the ATA task file over the normal CPU path, then hands bulk data movement to this block.

Parameters:
- FIFO_DEPTH, 16, host FIFO depth in words (power of 2).
- WORDS_PER_SECTOR, 256, words per sector.
- GAP, 4, minimum cycles cs5 stays high between accesses; must be at least the bridge's worst-case exprdy-rise-to-IDLE latency of 3.
- TIMEOUT, 255, maximum cycles in any exprdy wait before abort.

Ports:
- clk  in  1  system clock, the same clock as the bridge.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- dir  in  1  1 = read (drive to host), 0 = write; sampled with start.
- nsectors  in  8  sector count; 0 means 256.
- abort  in  1  terminate after the current word completes.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of burst.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- cs5  out  1  active-low chip select to bridge.
- moe  out  1  active-low read strobe to bridge.
- mwe  out  1  active-low write strobe to bridge.
- a3, a2, a1, a0  out  1 each  register address; constant 0000 (data register).
- exprdy  in  1  from bridge; low = access in progress.
- d_in  in  16  IDE data bus (read path).
- d_out  out  16  write data to IDE data bus buffer.
- d_oe  out  1  drive enable for d_out.
- h_wr  in  1  host push (write dir).
- h_wdata  in  16  host push data.
- h_rd  in  1  host pop (read dir).
- h_rdata  out  16  FIFO head; valid when h_empty is low.
- h_full  out  1  FIFO full.
- h_empty  out  1  FIFO empty.
- h_level  out  5  FIFO occupancy (0..16).

Behaviour:
- Reset values: cs5=moe=mwe=1, d_oe=0, d_out=0, busy=0, done=0, err=0, FIFO empty (h_level=0, h_empty=1, h_full=0), remaining=0, state=IDLE.
- Word budget: on start, remaining (17 bit) = nsectors*WORDS_PER_SECTOR, where 0 maps to 256 sectors (65536 words). The FIFO is also flushed on start.
- FIFO behaviour:
  - Synchronous single-clock FIFO with first-word fall-through on h_rdata.
  - Push on a full FIFO and pop on an empty FIFO are ignored.
  - Simultaneous push and pop leaves the level unchanged.
  - The host port is usable only in the matching direction (h_wr when dir=0, h_rd when dir=1). The engine pushes on read and pops on write.
- State machine:
  - IDLE: start → SETUP; busy=1, err=0.
  - SETUP: stall while read with h_full, or write with h_empty.
    - Otherwise cs5=0.
    - For write: load d_out from the FIFO head, pop the FIFO, set d_oe=1.
    - Go to STROBE.
  - STROBE: moe=0 (read) or mwe=0 (write); go to WAIT_LO.
  - WAIT_LO: wait for exprdy==0, then go to WAIT_HI.
  - WAIT_HI: wait for exprdy==1.
    - In the rising cycle: read pushes d_in into the FIFO.
    - Set cs5=1, moe=1, mwe=1; decrement remaining; go to GAP.
  - GAP: d_oe drops on the first GAP cycle (one cycle of write-data hold past the strobe release). After GAP cycles:
    - remaining==0 or abort latched → DONE.
    - Otherwise → SETUP.
  - DONE: done=1 for one cycle, busy=0; go to IDLE.
- Timeout: a per-wait counter resets on entry to WAIT_LO and to WAIT_HI. If it reaches TIMEOUT:
  - err=1; release cs5, moe, mwe and d_oe.
  - Go to GAP, then DONE regardless of remaining.
- Abort: abort pulses are latched while busy. A latched abort takes effect only at the GAP exit and never truncates a bus cycle in progress. Abort in IDLE is ignored.
- Latency: minimum 4 cycles from SETUP to WAIT_HI; 1 word per access.
- Strobe hygiene: moe and mwe are never both low. Strobes go low only while cs5 is low, and all three go high in the same cycle.
- Reset mid-burst: all strobes release in the next cycle, the FIFO clears, and no done pulse is issued.

Test Plan:
- Read, nsectors=1, bridge model with a 16-cycle exprdy-low window, host pops continuously → 256 moe cycles, FIFO data equals the d_in sequence 0x0000..0x00FF, done exactly once, cs5 high ≥4 cycles between accesses.
- Write, nsectors=1, host pre-fills 16 words then pushes on demand → 256 mwe cycles with d_out matching push order, d_oe high through WAIT_HI plus 1 cycle, zero mwe-low cycles while the FIFO is empty.
- Read backpressure: host stops popping at h_level=16 → engine stays in SETUP with cs5=1; resumes one access after the first pop; no words lost or duplicated.
- Timeout: exprdy held at 1 after strobe → err=1 after 255 cycles, strobes released, done pulses, next start clears err.
- Abort issued mid-WAIT_HI on word 10 → word 10 completes, remaining words are not accessed, done pulses; also nsectors=0 → remaining loads 65536 (check the counter value only).
- Reset asserted in WAIT_LO → next cycle cs5=moe=mwe=1, d_oe=0, h_level=0, busy=0, no done.
